// File: rtl/picomips_pkg.sv
// Shared definitions for the picoMIPS datapath blocks: register-file address width,
// multiplier FSM states and the fractional-multiply saturation value.
package picomips_pkg;

    localparam int REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fmul_state_t;

    // Largest positive Q1.(width-1) value: returned for the single -1 * -1 overflow.
    function automatic int fmul_sat(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/fmul_extract.sv
// Picks the Q1.(n-1) result out of a 2n-bit signed product and saturates the -1 * -1 case.
module fmul_extract
    import picomips_pkg::*;
#(
    parameter int n = 8
) (
    input  logic [2*n-1:0] i_product,
    output logic [n-1:0]   o_result
);

    logic w_overflow;
    logic w_unused_lo;

    // Only -1 * -1 reaches +1.0, the one product whose top two bits disagree.
    assign w_overflow  = i_product[2*n-1] ^ i_product[2*n-2];
    assign w_unused_lo = ^i_product[n-2:0];

    assign o_result = w_overflow ? n'(fmul_sat(n)) : i_product[2*n-2:n-1];

endmodule

// File: rtl/fmul_seq.sv
// Sequential radix-2 Booth multiplier for Q1.(n-1) operands, one step per clock,
// feeding the register-file write-back path and stalling the PC while busy.
module fmul_seq
    import picomips_pkg::*;
#(
    parameter int n = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [n-1:0]          a,
    input  logic [n-1:0]          b,
    input  logic [REG_ADDR_W-1:0] waddr_in,
    output logic                  stall,
    output logic                  done,
    output logic [REG_ADDR_W-1:0] waddr_out,
    output logic [n-1:0]          result
);

    localparam int CNT_W = $clog2(n);

    fmul_state_t           r_state;
    fmul_state_t           w_next_state;
    logic [CNT_W-1:0]      r_count;
    logic [n-1:0]          r_mcand;
    logic [n-1:0]          r_q;
    logic [n:0]            r_acc;
    logic                  r_qm1;
    logic [REG_ADDR_W-1:0] r_waddr;
    logic                  r_done;
    logic [REG_ADDR_W-1:0] r_waddr_out;
    logic [n-1:0]          r_result;

    logic [n:0]            w_mcand_ext;
    logic [n:0]            w_sum;
    logic [n:0]            w_acc_next;
    logic [n-1:0]          w_q_next;
    logic [2*n-1:0]        w_prod;
    logic [n-1:0]          w_result;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: the default assignment first guarantees no latch is inferred on any path.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (r_count == '0) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign stall = ((r_state == IDLE) && start) || (r_state == RUN);

    // Booth step: the multiplier LSB pair selects add, subtract or skip, then the
    // {acc, q} pair shifts right arithmetically; acc carries one guard bit for -(-1).
    assign w_mcand_ext = {r_mcand[n-1], r_mcand};

    always_comb begin
        w_sum = r_acc;
        unique case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + w_mcand_ext;
            2'b10:   w_sum = r_acc - w_mcand_ext;
            default: w_sum = r_acc;
        endcase
    end

    assign w_acc_next = {w_sum[n], w_sum[n:1]};
    assign w_q_next   = {w_sum[0], r_q[n-1:1]};
    assign w_prod     = {w_acc_next[n-1:0], w_q_next};

    fmul_extract #(.n(n)) u_extract (
        .i_product (w_prod),
        .o_result  (w_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_mcand     <= '0;
            r_q         <= '0;
            r_acc       <= '0;
            r_qm1       <= 1'b0;
            r_waddr     <= '0;
            r_done      <= 1'b0;
            r_waddr_out <= '0;
            r_result    <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand <= a;
                        r_q     <= b;
                        r_acc   <= '0;
                        r_qm1   <= 1'b0;
                        r_waddr <= waddr_in;
                        r_count <= CNT_W'(n - 1);
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    r_q   <= w_q_next;
                    r_qm1 <= r_q[0];
                    if (r_count == '0) begin
                        r_result    <= w_result;
                        r_waddr_out <= r_waddr;
                        r_done      <= 1'b1;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done      = r_done;
    assign waddr_out = r_waddr_out;
    assign result    = r_result;

endmodule

// File: tb/tb_fmul_seq.sv
// Scoreboard bench for fmul_seq (n=8): stimulus pushes hand-computed products with
// their expected done cycle; a negedge monitor pops and compares on every done pulse.
module tb_fmul_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] waddr_in;
    logic       stall;
    logic       done;
    logic [2:0] waddr_out;
    logic [7:0] result;

    typedef struct {
        logic [7:0] res;
        logic [2:0] addr;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    fmul_seq #(.n(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .waddr_in  (waddr_in),
        .stall     (stall),
        .done      (done),
        .waddr_out (waddr_out),
        .result    (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1 with result 0x%0h, expected no pulse (cycle %0d)",
                         result, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", {24'd0, result}, {24'd0, mon_e.res});
                check("waddr_out", {29'd0, waddr_out}, {29'd0, mon_e.addr});
                check("done_cycle", cyc, mon_e.cyc);
                check("stall_in_done", {31'd0, stall}, 32'd0);
            end
        end
    end

    // One multiply: start for a single cycle, then stall is checked through DONE.
    // With scramble set, operands and start are randomised during RUN.
    task automatic do_mul(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] tw,
                          input logic [7:0] texp, input bit scramble);
        @(negedge clk);
        a        = ta;
        b        = tb_v;
        waddr_in = tw;
        start    = 1'b1;
        sb_q.push_back('{res: texp, addr: tw, cyc: cyc + 9});
        #1 check("stall_start", {31'd0, stall}, 32'd1);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (scramble) begin
                a        = 8'($urandom);
                b        = 8'($urandom);
                waddr_in = 3'($urandom);
                start    = (i < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                start = 1'b0;
            end
            #1 check("stall_op", {31'd0, stall}, (i < 9) ? 32'd1 : 32'd0);
        end
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        waddr_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", {24'd0, result}, 32'd0);
        check("reset_waddr", {29'd0, waddr_out}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);

        // Reset during RUN aborts the operation without a write strobe.
        @(negedge clk);
        a = 8'h40; b = 8'h40; waddr_in = 3'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_stall", {31'd0, stall}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1 check("abort_no_done", {31'd0, done}, 32'd0);
        end

        // Basic products, signs, truncation and saturation.
        do_mul(8'h40, 8'h40, 3'd3, 8'h20, 1'b0);
        do_mul(8'hC0, 8'h40, 3'd1, 8'hE0, 1'b0);
        do_mul(8'hFF, 8'h01, 3'd2, 8'hFF, 1'b0);
        do_mul(8'h7F, 8'h7F, 3'd4, 8'h7E, 1'b0);
        do_mul(8'h80, 8'h7F, 3'd6, 8'h81, 1'b0);
        do_mul(8'h80, 8'h80, 3'd7, 8'h7F, 1'b0);
        do_mul(8'h80, 8'h01, 3'd0, 8'hFF, 1'b0);

        // Latched operands: 0x60 * 0xA0 = 0.75 * -0.75 -> -0.5625 = 0xB8.
        do_mul(8'h60, 8'hA0, 3'd5, 8'hB8, 1'b1);

        // Back-to-back with start held: done every 10 cycles, stall low only then.
        @(negedge clk);
        a = 8'h20; b = 8'h20; waddr_in = 3'd2; start = 1'b1;
        for (int k = 0; k < 3; k++) sb_q.push_back('{res: 8'h08, addr: 3'd2, cyc: cyc + 9 + 10 * k});
        for (int i = 0; i < 30; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 29) start = 1'b0;
            #1 check("b2b_stall", {31'd0, stall}, (i == 9 || i == 19 || i == 29) ? 32'd0 : 32'd1);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
